// File: rtl/etc_lane_tracker.sv
// ---------------------------------------------------------------------------
// etc_lane_tracker
//
// Non-stop ETC lane core. Keeps a small in-order queue of the vehicles that
// are between the entry loop (sensor1) and the exit loop (sensor3). Each
// vehicle is timestamped at entry; when it crosses the speed loop (sensor2)
// the elapsed milliseconds are divided into DIST_CM*36 to give km/h. The
// barrier follows the vehicle at the head of the queue: open only once that
// vehicle has been measured, carries a valid Epass and is not speeding.
//
// Ports
//   clk          clock
//   reset_n      asynchronous active-low reset
//   sensor1      entry loop, active high
//   sensor2      speed loop, active high
//   sensor3      exit loop, active high
//   valid_Epass  tag status: 01 valid, anything else not valid
//   enable       maintenance override, forces the barrier open
//   speed        last measured speed in km/h (saturating)
//   speed_valid  one-cycle pulse when speed/overspeed update
//   overspeed    speed > SPEED_LIMIT, qualified by speed_valid
//   done         one-cycle pulse after a vehicle retires at sensor3
//   barrier      1 = open
//   occupancy    vehicles currently tracked
//   error        sticky protocol error
// ---------------------------------------------------------------------------
module etc_lane_tracker #(
  parameter int WIDTH_TIK   = 16,
  parameter int WIDTH_MS    = 14,
  parameter int WIDTH_SPEED = 14,
  parameter int SYS_FREQ    = 10000000,
  parameter int DEPTH       = 4,
  parameter int DIST_CM     = 500,
  parameter int SPEED_LIMIT = 80
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sensor1,
  input  logic                         sensor2,
  input  logic                         sensor3,
  input  logic [1:0]                   valid_Epass,
  input  logic                         enable,
  output logic [WIDTH_SPEED-1:0]       speed,
  output logic                         speed_valid,
  output logic                         overspeed,
  output logic                         done,
  output logic                         barrier,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         error
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [WIDTH_TIK-1:0] TIK_MAX = WIDTH_TIK'(SYS_FREQ/1000 - 1);
  // cm -> km/h scaling: (cm / ms) * 36 = km/h
  localparam logic [31:0] K_DIST = 32'(DIST_CM * 36);

  typedef enum logic [1:0] {
    DIV_IDLE,  // waiting for a sensor2 crossing
    DIV_RUN,   // 32 restoring iterations
    DIV_SAT,   // clamp quotient to the speed width
    DIV_PUB    // publish result and mark the entry measured
  } div_state_t;

  // Edge detection
  logic s1_q, s2_q, s3_q;
  logic s1_rise, s2_rise, s3_rise;

  // Millisecond timebase
  logic [WIDTH_TIK-1:0] tik;
  logic [WIDTH_MS-1:0]  ms_now;

  // Vehicle queue
  logic [WIDTH_MS-1:0] ts_mem [DEPTH];
  logic [DEPTH-1:0]    epass_ok;
  logic [DEPTH-1:0]    ovs;
  logic [DEPTH-1:0]    measured;
  logic [PW-1:0]       head, tail, s2p;
  logic [OW-1:0]       occ, s2_pend;

  // Divider
  div_state_t           div_state;
  logic [4:0]           div_cnt;
  logic [PW-1:0]        div_idx;
  logic [WIDTH_MS-1:0]  divisor;
  logic [31:0]          rem, quo;
  logic [31:0]          rem_nxt, quo_nxt;
  logic [32:0]          rem_sh, diff;
  logic [WIDTH_SPEED-1:0] res_speed;
  logic                 res_ovs;
  logic [WIDTH_SPEED-1:0] sat_speed;

  logic                 barrier_q;

  // Per-cycle decisions, all taken from start-of-cycle state
  logic full, pop, push, s2_start, err_now;
  logic [WIDTH_MS-1:0] delta;

  assign s1_rise = sensor1 & ~s1_q;
  assign s2_rise = sensor2 & ~s2_q;
  assign s3_rise = sensor3 & ~s3_q;

  assign full     = (occ == OW'(DEPTH));
  assign pop      = s3_rise & (occ != '0) & measured[head];
  // A full queue can still accept an entry when the head leaves in the same cycle.
  assign push     = s1_rise & (~full | pop);
  assign s2_start = s2_rise & (s2_pend != '0) & (div_state == DIV_IDLE);
  assign err_now  = (s1_rise & full & ~pop)
                  | (s2_rise & ~s2_start)
                  | (s3_rise & ~pop);

  // Modular subtraction handles ms_now wrapping between the two loops.
  assign delta = ms_now - ts_mem[s2p];

  // One restoring-division step: shift the next dividend bit in, subtract if it fits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - 33'(divisor);
    rem_nxt = rem_sh[31:0];
    quo_nxt = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  // Zero elapsed time divides to all ones; clamp that and any too-large quotient.
  assign sat_speed = ((divisor == '0) || (quo[31:WIDTH_SPEED] != '0))
                   ? '1 : quo[WIDTH_SPEED-1:0];

  // Entry timestamps carry no meaning until written by a push, so they
  // are left out of reset.
  // NOTE: queue storage is not reset; only the valid/status flags are.
  always_ff @(posedge clk) begin
    if (push) ts_mem[tail] <= ms_now;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      tik         <= '0;
      ms_now      <= '0;
      epass_ok    <= '0;
      ovs         <= '0;
      measured    <= '0;
      head        <= '0;
      tail        <= '0;
      s2p         <= '0;
      occ         <= '0;
      s2_pend     <= '0;
      div_state   <= DIV_IDLE;
      div_cnt     <= '0;
      div_idx     <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      res_speed   <= '0;
      res_ovs     <= 1'b0;
      speed       <= '0;
      speed_valid <= 1'b0;
      overspeed   <= 1'b0;
      done        <= 1'b0;
      barrier_q   <= 1'b0;
      error       <= 1'b0;
    end else begin
      s1_q <= sensor1;
      s2_q <= sensor2;
      s3_q <= sensor3;

      if (tik == TIK_MAX) begin
        tik    <= '0;
        ms_now <= ms_now + WIDTH_MS'(1);
      end else begin
        tik <= tik + WIDTH_TIK'(1);
      end

      speed_valid <= 1'b0;
      done        <= pop;
      error       <= error | err_now;

      // Divider and its write-back into the queue entry it is measuring.
      case (div_state)
        DIV_IDLE: begin
          if (s2_start) begin
            div_state <= DIV_RUN;
            div_cnt   <= '0;
            div_idx   <= s2p;
            divisor   <= delta;
            rem       <= '0;
            quo       <= K_DIST;
          end
        end
        DIV_RUN: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) div_state <= DIV_SAT;
        end
        DIV_SAT: begin
          res_speed <= sat_speed;
          res_ovs   <= (sat_speed > WIDTH_SPEED'(SPEED_LIMIT));
          div_state <= DIV_PUB;
        end
        DIV_PUB: begin
          speed             <= res_speed;
          overspeed         <= res_ovs;
          speed_valid       <= 1'b1;
          ovs[div_idx]      <= res_ovs;
          measured[div_idx] <= 1'b1;
          div_state         <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase

      // The entry under division is never the free slot a push writes,
      // so these writes cannot collide with the write-back above.
      if (push) begin
        epass_ok[tail] <= (valid_Epass == 2'b01);
        ovs[tail]      <= 1'b0;
        measured[tail] <= 1'b0;
        tail           <= tail + PW'(1);
      end
      if (pop)      head <= head + PW'(1);
      if (s2_start) s2p  <= s2p + PW'(1);

      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase

      case ({push, s2_start})
        2'b10:   s2_pend <= s2_pend + OW'(1);
        2'b01:   s2_pend <= s2_pend - OW'(1);
        default: s2_pend <= s2_pend;
      endcase

      // Looks at the head as it stood at the start of this cycle, so a new
      // head (or a freshly measured one) shows up one cycle later.
      barrier_q <= (occ != '0) & measured[head] & epass_ok[head] & ~ovs[head];
    end
  end

  assign barrier   = enable | barrier_q;
  assign occupancy = occ;

endmodule

// File: tb/tb_etc_lane_tracker.sv
// ---------------------------------------------------------------------------
// tb_etc_lane_tracker
//
// Directed bench for etc_lane_tracker. The DUT runs with a 2 clk/ms timebase
// so the 14-bit millisecond wrap is reachable in a short run; all elapsed
// times below are in ms and expected speeds are floor(18000 / delta_ms),
// clamped to 16383.
//
// A bench-side cycle counter (cyc, cleared by reset) mirrors the timebase:
// the ms value seen by edge k after reset release is floor((k-1)/2).
// ---------------------------------------------------------------------------
module tb_etc_lane_tracker;

  localparam int WS = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sensor1, sensor2, sensor3;
  logic [1:0]    valid_Epass;
  logic          enable;
  logic [WS-1:0] speed;
  logic          speed_valid, overspeed, done, barrier, error;
  logic [2:0]    occupancy;

  etc_lane_tracker #(
    .WIDTH_TIK   (16),
    .WIDTH_MS    (14),
    .WIDTH_SPEED (WS),
    .SYS_FREQ    (2000),
    .DEPTH       (4),
    .DIST_CM     (500),
    .SPEED_LIMIT (80)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor1     (sensor1),
    .sensor2     (sensor2),
    .sensor3     (sensor3),
    .valid_Epass (valid_Epass),
    .enable      (enable),
    .speed       (speed),
    .speed_valid (speed_valid),
    .overspeed   (overspeed),
    .done        (done),
    .barrier     (barrier),
    .occupancy   (occupancy),
    .error       (error)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    int         delta_ms;
    logic [1:0] epass;
    int         exp_speed;
    logic       exp_ovs;
    logic       exp_barrier;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    sensor1     = 1'b0;
    sensor2     = 1'b0;
    sensor3     = 1'b0;
    valid_Epass = 2'b00;
    ticks(2);
    reset_n = 1'b1;
  endtask

  // Make the next edge index odd so an edge pair (a, a+1) shares one ms.
  task automatic align_even();
    if (cyc % 2 != 0) tick();
  endtask

  task automatic push(input logic [1:0] ep);
    sensor1     = 1'b1;
    valid_Epass = ep;
    tick();
    sensor1     = 1'b0;
    valid_Epass = 2'b00;
  endtask

  task automatic pulse(input int n);
    case (n)
      2:       sensor2 = 1'b1;
      3:       sensor3 = 1'b1;
      default: sensor1 = 1'b1;
    endcase
    tick();
    sensor1 = 1'b0;
    sensor2 = 1'b0;
    sensor3 = 1'b0;
  endtask

  // Called right after the sensor2 rise edge; result must land 34 edges later.
  task automatic wait_result(input string tag, input int exp_speed, input logic exp_ovs);
    ticks(33);
    check({tag, " valid_early"}, speed_valid, 0);
    tick();
    check({tag, " valid"}, speed_valid, 1);
    check({tag, " speed"}, speed, exp_speed);
    check({tag, " overspeed"}, overspeed, exp_ovs);
  endtask

  task automatic watch_no_valid(input string tag, input int n);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (speed_valid) saw = 1'b1;
    end
    check(tag, saw, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"v60",    300, 2'b01,    60, 1'b0, 1'b1};
    vecs[1] = '{"v90",    200, 2'b01,    90, 1'b1, 1'b0};
    vecs[2] = '{"v80lim", 225, 2'b01,    80, 1'b0, 1'b1};
    vecs[3] = '{"v82",    219, 2'b11,    82, 1'b1, 1'b0};
    vecs[4] = '{"v79tag0",226, 2'b00,    79, 1'b0, 1'b0};
    vecs[5] = '{"v64inv", 280, 2'b10,    64, 1'b0, 1'b0};
    vecs[6] = '{"v72",    250, 2'b01,    72, 1'b0, 1'b1};
    vecs[7] = '{"dzero",    0, 2'b01, 16383, 1'b1, 1'b0};
    vecs[8] = '{"d1sat",    1, 2'b01, 16383, 1'b1, 1'b0};
    vecs[9] = '{"d2",       2, 2'b01,  9000, 1'b1, 1'b0};

    // Reset state, with enable showing through the barrier.
    enable = 1'b1;
    do_reset();
    reset_n = 1'b0;
    #1;
    check("rst barrier=enable", barrier, 1);
    check("rst speed", speed, 0);
    check("rst valid", speed_valid, 0);
    check("rst overspeed", overspeed, 0);
    check("rst done", done, 0);
    check("rst occupancy", occupancy, 0);
    check("rst error", error, 0);
    enable = 1'b0;
    #1;
    check("rst barrier", barrier, 0);
    do_reset();

    // Single vehicle per vector: push, sensor2 after delta ms, retire.
    for (int i = 0; i < 10; i++) begin
      align_even();
      push(vecs[i].epass);
      check({vecs[i].name, " occ1"}, occupancy, 1);
      ticks(vecs[i].delta_ms == 0 ? 0 : 2 * vecs[i].delta_ms - 1);
      pulse(2);
      wait_result(vecs[i].name, vecs[i].exp_speed, vecs[i].exp_ovs);
      check({vecs[i].name, " barrier_pre"}, barrier, 0);
      tick();
      check({vecs[i].name, " barrier"}, barrier, {31'd0, vecs[i].exp_barrier});
      pulse(3);
      check({vecs[i].name, " done"}, done, 1);
      check({vecs[i].name, " occ0"}, occupancy, 0);
      tick();
      check({vecs[i].name, " done_end"}, done, 0);
      check({vecs[i].name, " barrier_end"}, barrier, 0);
      check({vecs[i].name, " error"}, error, 0);
    end

    // Full queue: held sensor1 counts once, overflow errors, full+pop accepted.
    do_reset();
    sensor1 = 1'b1;
    valid_Epass = 2'b01;
    ticks(3);
    sensor1 = 1'b0;
    tick();
    check("held s1 single push", occupancy, 1);
    for (int i = 0; i < 3; i++) begin
      pulse(1);
      tick();
    end
    check("full occ", occupancy, 4);
    check("full no error", error, 0);
    pulse(2);
    ticks(40);
    check("full head measured no error", error, 0);
    sensor1 = 1'b1;
    sensor3 = 1'b1;
    tick();
    sensor1 = 1'b0;
    sensor3 = 1'b0;
    check("full push+pop done", done, 1);
    check("full push+pop occ", occupancy, 4);
    tick();
    check("full push+pop no error", error, 0);
    pulse(1);
    check("overflow error", error, 1);
    check("overflow occ", occupancy, 4);

    // sensor2 on empty queue.
    do_reset();
    pulse(2);
    check("s2 empty error", error, 1);
    check("s2 empty occ", occupancy, 0);
    watch_no_valid("s2 empty no result", 40);

    // sensor1 + sensor2 together on empty queue: push kept, sensor2 rejected.
    do_reset();
    align_even();
    sensor1 = 1'b1;
    sensor2 = 1'b1;
    valid_Epass = 2'b01;
    tick();
    sensor1 = 1'b0;
    sensor2 = 1'b0;
    check("s1+s2 error", error, 1);
    check("s1+s2 occ", occupancy, 1);
    ticks(20);
    pulse(2);
    wait_result("s1+s2 later", 1800, 1);

    // sensor3 before head is measured.
    do_reset();
    push(2'b01);
    tick();
    pulse(3);
    check("early s3 error", error, 1);
    check("early s3 occ", occupancy, 1);
    check("early s3 done", done, 0);

    // A (invalid tag) ahead of B (valid tag), both 60 km/h.
    do_reset();
    align_even();
    push(2'b10);
    ticks(39);
    push(2'b01);
    ticks(559);
    pulse(2);
    wait_result("A", 60, 0);
    ticks(5);
    pulse(2);
    wait_result("B", 60, 0);
    tick();
    check("A head barrier", barrier, 0);
    check("A+B occ", occupancy, 2);
    enable = 1'b1;
    #1;
    check("enable override", barrier, 1);
    enable = 1'b0;
    #1;
    check("enable released", barrier, 0);
    pulse(3);
    check("A done", done, 1);
    check("A popped occ", occupancy, 1);
    tick();
    check("B head barrier", barrier, 1);
    pulse(3);
    check("B done", done, 1);
    tick();
    check("B popped barrier", barrier, 0);
    check("A+B no error", error, 0);

    // Timestamp wrap: entry at ms 16380, sensor2 at ms 276.
    do_reset();
    while (cyc < 32760) tick();
    push(2'b01);
    ticks(559);
    pulse(2);
    wait_result("wrap", 64, 0);
    tick();
    check("wrap barrier", barrier, 1);
    pulse(3);
    tick();

    // Reset in the middle of a division.
    push(2'b01);
    ticks(9);
    pulse(2);
    ticks(10);
    reset_n = 1'b0;
    #1;
    check("midrst speed", speed, 0);
    check("midrst overspeed", overspeed, 0);
    check("midrst valid", speed_valid, 0);
    check("midrst occ", occupancy, 0);
    check("midrst error", error, 0);
    check("midrst barrier", barrier, 0);
    tick();
    reset_n = 1'b1;
    watch_no_valid("midrst no result", 40);
    check("midrst error after", error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
